// File: rtl/flip_filter_pkg.sv
// flip_filter_pkg: shared types and constants for the flip filter.
//   state_e   : serializer FSM states (IDLE, DRAIN, DONE)
//   MAX_PORTS : upper bound on NUM_PORTS supported by the grant cascade
package flip_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int MAX_PORTS = 8;

endpackage

// File: rtl/flip_grant_cascade.sv
// flip_grant_cascade: NUM_PORTS-deep LSB-isolation cascade over the
// remaining candidate vector. Stage k sees the vector with the grants of
// stages 0..k-1 removed, so port k gets the k-th lowest set bit.
//   vec_i        : remaining candidate vector (already in priority order)
//   msb_i        : vector is bit-reversed; map indices back to original numbering
//   port_en_i    : ports that will actually issue this beat
//   found_o      : stage k has a set bit
//   idx_o        : per-port index, original numbering, zero when port disabled
//   grant_mask_o : OR of the one-hots of enabled ports
module flip_grant_cascade #(
  parameter int NUM_REQ   = 256,
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]                  vec_i,
  input  logic                                msb_i,
  input  logic [NUM_PORTS-1:0]                port_en_i,
  output logic [NUM_PORTS-1:0]                found_o,
  output logic [NUM_PORTS-1:0][IDX_W-1:0]     idx_o,
  output logic [NUM_REQ-1:0]                  grant_mask_o
);

  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   TOP_IDX = IDX_W'(NUM_REQ - 1);

  logic [NUM_PORTS-1:0][NUM_REQ-1:0] rem;
  logic [NUM_PORTS-1:0][NUM_REQ-1:0] onehot;
  logic [NUM_PORTS-1:0][IDX_W-1:0]   idx_raw;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign rem[k] = vec_i;
    end else begin : g_next
      assign rem[k] = rem[k-1] & ~onehot[k-1];
    end
    // x & -x isolates the lowest set bit
    assign onehot[k]  = rem[k] & (~rem[k] + ONE);
    assign found_o[k] = |rem[k];
  end

  // one-hot to binary: OR together the indices of set bits
  always_comb begin
    idx_raw      = '0;
    idx_o        = '0;
    grant_mask_o = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (onehot[k][i]) idx_raw[k] = idx_raw[k] | IDX_W'(i);
      end
      if (port_en_i[k]) begin
        idx_o[k]     = msb_i ? (TOP_IDX - idx_raw[k]) : idx_raw[k];
        grant_mask_o = grant_mask_o | onehot[k];
      end
    end
  end

endmodule

// File: rtl/flip_grant_serializer.sv
// flip_grant_serializer: accepts one flip-candidate vector per batch and
// drains it as up to NUM_PORTS indices per beat, LSB- or MSB-first, capped
// by a per-batch flip budget.
//   clk_i, rst_i         : clock, async active-high reset
//   en_i                 : global stall (freezes state, gates idx_valid_o)
//   flush_i              : synchronous abort to IDLE
//   req_valid_i/ready_o  : batch handshake; req_i, msb_first_i, max_flips_i
//                          sampled on accept
//   idx_valid_o/idx_o    : per-port index beat; idx_ready_i accepts whole beat
//   last_o               : current beat ends the batch
//   busy_o, done_o       : batch in progress / completion pulse
//   count_o              : flips issued in current or last batch
import flip_filter_pkg::*;

module flip_grant_serializer #(
  parameter int NUM_REQ   = 256,
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       msb_first_i,
  input  logic [IDX_W:0]             max_flips_i,
  output logic [NUM_PORTS-1:0]       idx_valid_o,
  output logic [NUM_PORTS*IDX_W-1:0] idx_o,
  input  logic                       idx_ready_i,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [IDX_W:0]             count_o
);

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  state_e                          state_q, state_d;
  logic [NUM_REQ-1:0]              vec_q, vec_d, req_ord, grant_mask;
  logic [IDX_W:0]                  budget_q, budget_d, count_q, count_d, n_grant;
  logic                            msb_q, msb_d;
  logic [NUM_PORTS-1:0]            found, port_en;
  logic [NUM_PORTS-1:0][IDX_W-1:0] idx;
  logic                            last, fire;

  // MSB mode stores the vector reversed so the cascade is always LSB-first
  always_comb begin
    req_ord = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ord[i] = msb_first_i ? req_i[NUM_REQ-1-i] : req_i[i];
  end

  flip_grant_cascade #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_cascade (
    .vec_i        (vec_q),
    .msb_i        (msb_q),
    .port_en_i    (port_en),
    .found_o      (found),
    .idx_o        (idx),
    .grant_mask_o (grant_mask)
  );

  // port enables come from registered state only; en_i gates at the output
  always_comb begin
    port_en = '0;
    n_grant = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      port_en[k] = (state_q == ST_DRAIN) & found[k] & ((IDX_W+1)'(k) < budget_q);
      n_grant    = n_grant + (IDX_W+1)'(port_en[k]);
    end
  end

  assign last = port_en[0] & (((vec_q & ~grant_mask) == '0) | (budget_q == n_grant));
  assign fire = en_i & idx_ready_i & port_en[0];

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    budget_d = budget_q;
    count_d  = count_q;
    msb_d    = msb_q;
    if (flush_i) begin
      state_d  = ST_IDLE;
      vec_d    = '0;
      budget_d = '0;
      count_d  = '0;
      msb_d    = 1'b0;
    end else if (en_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            vec_d    = req_ord;
            msb_d    = msb_first_i;
            budget_d = (max_flips_i == '0 || max_flips_i > NREQ) ? NREQ : max_flips_i;
            count_d  = '0;
            state_d  = (|req_ord) ? ST_DRAIN : ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (fire) begin
            vec_d    = vec_q & ~grant_mask;
            budget_d = budget_q - n_grant;
            count_d  = count_q + n_grant;
            if (last) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      budget_q <= '0;
      count_q  <= '0;
      msb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      budget_q <= budget_d;
      count_q  <= count_d;
      msb_q    <= msb_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_DRAIN) | (state_q == ST_DONE);
  assign done_o      = (state_q == ST_DONE);
  assign count_o     = count_q;
  assign idx_valid_o = port_en & {NUM_PORTS{en_i}};
  assign last_o      = last & en_i;
  assign idx_o       = idx;

endmodule

// File: tb/tb_flip_grant_serializer.sv
module tb_flip_grant_serializer;

  localparam int NR = 16;
  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        rst_i, en_i, flush_i, req_valid_i, req_ready_o;
  logic [15:0] req_i;
  logic        msb_first_i;
  logic [4:0]  max_flips_i;
  logic [1:0]  idx_valid_o;
  logic [7:0]  idx_o;
  logic        idx_ready_i, last_o, busy_o, done_o;
  logic [4:0]  count_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flip_grant_serializer #(.NUM_REQ(NR), .NUM_PORTS(NP)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
    .msb_first_i(msb_first_i), .max_flips_i(max_flips_i),
    .idx_valid_o(idx_valid_o), .idx_o(idx_o), .idx_ready_i(idx_ready_i),
    .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list set bits in priority order, truncate to budget, chunk by NP.
  task automatic run_batch(input logic [15:0] req, input logic msb,
                           input logic [4:0] mx, input int stall_pct);
    int exp_idx[$];
    int budget, pos, cyc, nv;
    budget = (mx == 0 || mx > NR) ? NR : int'(mx);
    for (int j = 0; j < NR; j++) begin
      int b;
      b = msb ? (NR - 1 - j) : j;
      if (req[b] && exp_idx.size() < budget) exp_idx.push_back(b);
    end
    @(negedge clk);
    en_i = 1'b1; flush_i = 1'b0; idx_ready_i = 1'b0;
    req_valid_i = 1'b1; req_i = req; msb_first_i = msb; max_flips_i = mx;
    #1 chk("ready_idle", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0; req_i = 16'($urandom); msb_first_i = 1'($urandom);
    max_flips_i = 5'($urandom);
    pos = 0; cyc = 0;
    while (pos < exp_idx.size() && cyc < 200) begin
      idx_ready_i = ($urandom_range(99) >= stall_pct);
      #1;
      nv = (exp_idx.size() - pos >= 2) ? 2 : 1;
      chk("beat_valid", {30'd0, idx_valid_o}, (nv == 2) ? 32'd3 : 32'd1);
      chk("beat_idx0", {28'd0, idx_o[3:0]}, exp_idx[pos]);
      if (nv == 2) chk("beat_idx1", {28'd0, idx_o[7:4]}, exp_idx[pos+1]);
      chk("beat_last", {31'd0, last_o}, (pos + nv == exp_idx.size()) ? 32'd1 : 32'd0);
      chk("beat_count", {27'd0, count_o}, pos);
      chk("beat_done_low", {31'd0, done_o}, 32'd0);
      if (idx_ready_i) pos += nv;
      cyc++;
      @(negedge clk);
    end
    chk("beats_done", pos, exp_idx.size());
    idx_ready_i = 1'b0;
    #1;
    chk("done_pulse", {31'd0, done_o}, 32'd1);
    chk("done_novalid", {30'd0, idx_valid_o}, 32'd0);
    chk("done_count", {27'd0, count_o}, exp_idx.size());
    @(negedge clk);
    #1;
    chk("post_ready", {31'd0, req_ready_o}, 32'd1);
    chk("post_done_low", {31'd0, done_o}, 32'd0);
    chk("post_count", {27'd0, count_o}, exp_idx.size());
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_i = '0;
    msb_first_i = 1'b0; max_flips_i = '0; idx_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_valid", {30'd0, idx_valid_o}, 32'd0);
    chk("rst_count", {27'd0, count_o}, 32'd0);
    rst_i = 1'b0;

    run_batch(16'h8421, 1'b0, 5'd0, 0);
    run_batch(16'h8421, 1'b1, 5'd0, 0);
    run_batch(16'h00F0, 1'b0, 5'd3, 0);
    run_batch(16'h0000, 1'b0, 5'd0, 0);
    run_batch(16'hFFFF, 1'b1, 5'd20, 0);

    // stall, en_i freeze, then flush mid-drain
    @(negedge clk);
    req_valid_i = 1'b1; req_i = 16'hFFFF; msb_first_i = 1'b0; max_flips_i = '0;
    idx_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (3) begin
      #1;
      chk("stall_valid", {30'd0, idx_valid_o}, 32'd3);
      chk("stall_idx", {24'd0, idx_o}, 32'h10);
      chk("stall_last", {31'd0, last_o}, 32'd0);
      @(negedge clk);
    end
    en_i = 1'b0; idx_ready_i = 1'b1;
    repeat (2) begin
      #1;
      chk("en_low_valid", {30'd0, idx_valid_o}, 32'd0);
      chk("en_low_count", {27'd0, count_o}, 32'd0);
      chk("en_low_busy", {31'd0, busy_o}, 32'd1);
      @(negedge clk);
    end
    en_i = 1'b1;
    #1 chk("resume_idx", {24'd0, idx_o}, 32'h10);
    @(negedge clk);
    #1;
    chk("second_idx", {24'd0, idx_o}, 32'h32);
    chk("second_count", {27'd0, count_o}, 32'd2);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; idx_ready_i = 1'b0;
    #1;
    chk("flush_ready", {31'd0, req_ready_o}, 32'd1);
    chk("flush_done", {31'd0, done_o}, 32'd0);
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_count", {27'd0, count_o}, 32'd0);

    // async reset between edges mid-drain
    @(negedge clk);
    req_valid_i = 1'b1; req_i = 16'h0FF0; idx_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    #1 chk("pre_rst_valid", {30'd0, idx_valid_o}, 32'd3);
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_valid", {30'd0, idx_valid_o}, 32'd0);
    chk("arst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("arst_count", {27'd0, count_o}, 32'd0);
    #1 rst_i = 1'b0;
    idx_ready_i = 1'b0;
    run_batch(16'h8421, 1'b0, 5'd0, 0);

    for (int t = 0; t < 25; t++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (t % 3 == 0) r = r & 16'($urandom);
      run_batch(r, 1'($urandom), 5'($urandom_range(0, 20)), 35);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
